// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, bus field offsets and stall encoding for the
// MEM pipeline stage.
//   EX bus   : {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38],
//              rf_we[37], rf_waddr[36:32], ex_result[31:0]}
//   WB bus   : {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
//   RF bus   : {fwd_we[37], rf_waddr[36:32], rf_wdata[31:0]}
package mem_stage_pkg;

  localparam int unsigned EX_TO_MEM_WD_DEF = 76;
  localparam int unsigned MEM_TO_WB_WD_DEF = 70;
  localparam int unsigned MEM_TO_RF_WD_DEF = 38;

  // Stall vector: one bit per pipeline stage
  localparam int unsigned STALL_WD  = 6;
  localparam int unsigned STALL_MEM = 3;
  localparam int unsigned STALL_WB  = 4;

  // EX -> MEM bus field offsets
  localparam int unsigned EX_PC_LSB     = 44;
  localparam int unsigned EX_RAM_EN     = 43;
  localparam int unsigned EX_RAM_WEN_LSB = 39;
  localparam int unsigned EX_SEL_RF_RES = 38;
  localparam int unsigned EX_RF_WE      = 37;
  localparam int unsigned EX_WADDR_LSB  = 32;
  localparam int unsigned EX_RESULT_LSB = 0;

  typedef enum logic {
    NO_STOP = 1'b0,
    STOP    = 1'b1
  } stop_e;

endpackage

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Registers the EX bus under stall control,
// selects SRAM load data or the EX result as the write-back value, and keeps
// the SRAM read data while MEM and WB are both stalled.
// Ports:
//   clk             clock, all state on posedge
//   rst             asynchronous reset, active-low
//   stall           stall vector; [3]=MEM, [4]=WB, 1 = stop
//   ex_to_mem_bus   instruction from EX
//   data_sram_rdata SRAM read data, valid in the first MEM cycle
//   mem_to_wb_bus   {pc, rf_we, rf_waddr, rf_wdata} to WB
//   mem_to_rf_bus   {fwd_we, rf_waddr, rf_wdata} bypass to ID
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned EX_TO_MEM_WD = EX_TO_MEM_WD_DEF,
  parameter int unsigned MEM_TO_WB_WD = MEM_TO_WB_WD_DEF,
  parameter int unsigned MEM_TO_RF_WD = MEM_TO_RF_WD_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);

  logic [EX_TO_MEM_WD-1:0] bus_r;
  logic [31:0]             hold_data;
  logic                    hold_vld;

  stop_e mem_stop;
  stop_e wb_stop;
  logic  bubble;
  logic  advance;
  logic  bus_wr;

  logic [31:0] pc;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic        is_load;
  logic [31:0] mem_rdata;
  logic [31:0] rf_wdata;
  logic        fwd_we;

  // Only the MEM and WB stall bits matter to this stage
  logic unused_stall;
  assign unused_stall = ^{stall[STALL_WD-1:STALL_WB+1], stall[STALL_MEM-1:0]};

  assign mem_stop = stop_e'(stall[STALL_MEM]);
  assign wb_stop  = stop_e'(stall[STALL_WB]);

  always_comb begin
    bubble  = (mem_stop == STOP) && (wb_stop == NO_STOP);
    advance = (mem_stop == NO_STOP);
    bus_wr  = bubble || advance;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_r <= '0;
    end else if (bubble) begin
      bus_r <= '0;
    end else if (advance) begin
      bus_r <= ex_to_mem_bus;
    end
  end

  assign pc         = bus_r[EX_PC_LSB +: 32];
  assign ram_en     = bus_r[EX_RAM_EN];
  assign ram_wen    = bus_r[EX_RAM_WEN_LSB +: 4];
  assign sel_rf_res = bus_r[EX_SEL_RF_RES];
  assign rf_we      = bus_r[EX_RF_WE];
  assign rf_waddr   = bus_r[EX_WADDR_LSB +: 5];
  assign ex_result  = bus_r[EX_RESULT_LSB +: 32];

  assign is_load = ram_en && (ram_wen == 4'b0000) && sel_rf_res;

  // Any write of bus_r clears the hold ahead of a capture; a capture can
  // therefore only happen when MEM and WB are both stopped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_data <= '0;
      hold_vld  <= 1'b0;
    end else if (bus_wr) begin
      hold_vld  <= 1'b0;
    end else if (is_load && !hold_vld) begin
      hold_data <= data_sram_rdata;
      hold_vld  <= 1'b1;
    end
  end

  always_comb begin
    mem_rdata = hold_vld ? hold_data : data_sram_rdata;
    rf_wdata  = sel_rf_res ? mem_rdata : ex_result;
    fwd_we    = rf_we && (rf_waddr != 5'd0);
  end

  assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
  assign mem_to_rf_bus = {fwd_we, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic [75:0] ex_bus = '0;
  logic [31:0] rdata = '0;
  logic [69:0] wb_bus;
  logic [37:0] rf_bus;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [75:0] bus;
    logic [31:0] rd;
  } sb_t;

  sb_t sb[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .ex_to_mem_bus  (ex_bus),
    .data_sram_rdata(rdata),
    .mem_to_wb_bus  (wb_bus),
    .mem_to_rf_bus  (rf_bus)
  );

  function automatic logic [75:0] mk(input logic [31:0] pc, input logic ram_en,
                                     input logic [3:0] wen, input logic sel,
                                     input logic we, input logic [4:0] waddr,
                                     input logic [31:0] res);
    return {pc, ram_en, wen, sel, we, waddr, res};
  endfunction

  function automatic logic is_ld(input logic [75:0] b);
    return b[43] && (b[42:39] == 4'b0000) && b[38];
  endfunction

  // Expected {wb_bus, rf_bus} for an instruction given the load data seen
  function automatic logic [107:0] model(input logic [75:0] b, input logic [31:0] rd);
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    pc = b[75:44];
    we = b[37];
    wa = b[36:32];
    wd = b[38] ? rd : b[31:0];
    return {pc, we, wa, wd, (we && (wa != 5'd0)), wa, wd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [75:0] b;
    #2;
    total++;
    if ({wb_bus, rf_bus} !== 108'd0) begin
      bad++;
      $display("FAIL reset_state wb=%h rf=%h exp 0", wb_bus, rf_bus);
    end
    @(negedge clk);
    rst = 1'b1;
    // stalled load so the hold register is live when reset hits
    b = mk(32'hBFC0_0100, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h0);
    ex_bus = b;
    tick();
    rdata = 32'h1111_2222;
    stall = 6'b011000;
    tick();
    total++;
    if (dut.hold_vld !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_hold hold_vld=%b exp 1", dut.hold_vld);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({wb_bus, rf_bus} !== 108'd0 || dut.hold_vld !== 1'b0) begin
      bad++;
      $display("FAIL reset_async wb=%h rf=%h hold_vld=%b exp 0", wb_bus, rf_bus, dut.hold_vld);
    end
    @(negedge clk);
    stall = '0;
    ex_bus = '0;
    rst = 1'b1;
  endtask

  task automatic test_alu();
    sb_t e;
    logic [107:0] x;
    ex_bus = mk(32'hBFC0_0010, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
    sb.push_back('{ex_bus, 32'h0});
    tick();
    ex_bus = '0;
    rdata = 32'h5A5A_5A5A;
    #1;
    e = sb.pop_front();
    x = model(e.bus, e.rd);
    total++;
    if ({wb_bus, rf_bus} !== x) begin
      bad++;
      $display("FAIL alu wb=%h rf=%h exp %h", wb_bus, rf_bus, x);
    end
    total++;
    if (wb_bus[31:0] !== 32'h1234 || rf_bus[37] !== 1'b1 || rf_bus[36:32] !== 5'd5) begin
      bad++;
      $display("FAIL alu_fields wdata=%h fwd_we=%b waddr=%0d exp 1234/1/5",
               wb_bus[31:0], rf_bus[37], rf_bus[36:32]);
    end
  endtask

  task automatic test_load();
    sb_t e;
    logic [107:0] x;
    ex_bus = mk(32'hBFC0_0020, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h0000_5555);
    sb.push_back('{ex_bus, 32'hDEAD_BEEF});
    tick();
    ex_bus = '0;
    rdata = 32'hDEAD_BEEF;
    #1;
    e = sb.pop_front();
    x = model(e.bus, e.rd);
    total++;
    if ({wb_bus, rf_bus} !== x || wb_bus[31:0] !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL load wb=%h rf=%h exp %h", wb_bus, rf_bus, x);
    end
  endtask

  task automatic test_load_stall();
    sb_t e;
    logic [107:0] x;
    ex_bus = mk(32'hBFC0_0030, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h0000_7777);
    sb.push_back('{ex_bus, 32'hCAFE_F00D});
    tick();
    stall = 6'b011000;
    ex_bus = mk(32'hBFC0_0034, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h0000_00AB);
    for (int c = 0; c < 3; c++) begin
      rdata = (c == 0) ? 32'hCAFE_F00D : 32'hFFFF_FFFF;
      #1;
      x = model(sb[0].bus, sb[0].rd);
      total++;
      if ({wb_bus, rf_bus} !== x || wb_bus[31:0] !== 32'hCAFE_F00D) begin
        bad++;
        $display("FAIL load_stall_c%0d wb=%h rf=%h exp %h", c, wb_bus, rf_bus, x);
      end
      if (c < 2) tick();
    end
    total++;
    if (dut.hold_vld !== 1'b1) begin
      bad++;
      $display("FAIL load_stall_hold hold_vld=%b exp 1", dut.hold_vld);
    end
    stall = '0;
    e = sb.pop_front();
    sb.push_back('{ex_bus, 32'h0});
    tick();
    ex_bus = '0;
    #1;
    e = sb.pop_front();
    x = model(e.bus, e.rd);
    total++;
    if ({wb_bus, rf_bus} !== x || dut.hold_vld !== 1'b0) begin
      bad++;
      $display("FAIL load_release wb=%h rf=%h hold_vld=%b exp %h/0", wb_bus, rf_bus, dut.hold_vld, x);
    end
  endtask

  task automatic test_bubble();
    sb_t e;
    logic [107:0] x;
    ex_bus = mk(32'hBFC0_0040, 1'b0, 4'h0, 1'b0, 1'b1, 5'd12, 32'hABCD_0001);
    sb.push_back('{ex_bus, 32'h0});
    tick();
    e = sb.pop_front();
    x = model(e.bus, e.rd);
    total++;
    if ({wb_bus, rf_bus} !== x) begin
      bad++;
      $display("FAIL bubble_pre wb=%h rf=%h exp %h", wb_bus, rf_bus, x);
    end
    stall = 6'b001000;
    ex_bus = mk(32'hBFC0_0044, 1'b0, 4'h0, 1'b0, 1'b1, 5'd13, 32'hABCD_0002);
    tick();
    total++;
    if ({wb_bus, rf_bus} !== 108'd0 || rf_bus[37] !== 1'b0) begin
      bad++;
      $display("FAIL bubble wb=%h rf=%h exp 0", wb_bus, rf_bus);
    end
    stall = '0;
    ex_bus = '0;
  endtask

  task automatic test_store_zero();
    sb_t e;
    logic [107:0] x;
    ex_bus = mk(32'hBFC0_0050, 1'b1, 4'hF, 1'b0, 1'b0, 5'd3, 32'h8000_0010);
    sb.push_back('{ex_bus, 32'h0});
    tick();
    ex_bus = mk(32'hBFC0_0054, 1'b0, 4'h0, 1'b0, 1'b1, 5'd0, 32'h0000_0099);
    sb.push_back('{ex_bus, 32'h0});
    rdata = 32'h3333_4444;
    #1;
    e = sb.pop_front();
    x = model(e.bus, e.rd);
    total++;
    if ({wb_bus, rf_bus} !== x || rf_bus[37] !== 1'b0 || wb_bus[69:38] !== 32'hBFC0_0050) begin
      bad++;
      $display("FAIL store wb=%h rf=%h exp %h", wb_bus, rf_bus, x);
    end
    tick();
    ex_bus = '0;
    #1;
    e = sb.pop_front();
    x = model(e.bus, e.rd);
    total++;
    if ({wb_bus, rf_bus} !== x || rf_bus[37] !== 1'b0 || wb_bus[37] !== 1'b1) begin
      bad++;
      $display("FAIL waddr0 wb=%h rf=%h exp %h", wb_bus, rf_bus, x);
    end
  endtask

  task automatic test_back_to_back();
    sb_t e;
    logic [107:0] x;
    logic [31:0] rd;
    logic [31:0] g;
    for (int i = 0; i < 40; i++) begin
      rd = $urandom;
      ex_bus = mk($urandom, 1'($urandom_range(1)), ($urandom_range(2) == 0) ? 4'($urandom) : 4'h0,
                  1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom), $urandom);
      sb.push_back('{ex_bus, rd});
      tick();
      rdata = rd;
      #1;
      x = model(sb[0].bus, sb[0].rd);
      total++;
      if ({wb_bus, rf_bus} !== x) begin
        bad++;
        $display("FAIL b2b_%0d wb=%h rf=%h exp %h", i, wb_bus, rf_bus, x);
      end
      if ($urandom_range(2) == 0) begin
        stall = 6'b011000;
        tick();
        g = $urandom;
        rdata = g;
        #1;
        // held loads keep the first-cycle data; anything else follows live rdata
        x = model(sb[0].bus, is_ld(sb[0].bus) ? sb[0].rd : g);
        total++;
        if ({wb_bus, rf_bus} !== x) begin
          bad++;
          $display("FAIL b2b_stall_%0d wb=%h rf=%h exp %h", i, wb_bus, rf_bus, x);
        end
        stall = '0;
      end
      e = sb.pop_front();
    end
    ex_bus = '0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_load_stall();
    test_bubble();
    test_store_zero();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
